// File: rtl/spi_boot_master.sv
// SPI/QPI boot master: serialises one write request at a time (memory write
// or register-0 write) onto SCK/CS/SDO0-3 in SPI mode 0. Write-only.
module spi_boot_master #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_req_valid_i,
    output logic        out_req_ready_o,
    input  logic        in_req_op_i,
    input  logic [31:0] in_req_addr_i,
    input  logic [31:0] in_req_data_i,
    input  logic        in_quad_en_i,
    output logic        out_spi_clk_o,
    output logic        out_spi_cs_o,
    output logic [1:0]  out_spi_mode_o,
    output logic        out_spi_sdo0_o,
    output logic        out_spi_sdo1_o,
    output logic        out_spi_sdo2_o,
    output logic        out_spi_sdo3_o,
    output logic        out_busy_o,
    output logic        out_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [7:0]  HALF_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_RELOAD  = 16'(GAP_CYCLES - 1);

    state_t      state_r,    state_s;
    logic [7:0]  half_cnt_r, half_cnt_s;
    logic [6:0]  per_cnt_r,  per_cnt_s;
    logic [15:0] gap_cnt_r,  gap_cnt_s;
    logic [71:0] shreg_r,    shreg_s;
    logic        quad_r,     quad_s;
    logic        sck_r,      sck_s;
    logic        cs_r,       cs_s;
    logic [3:0]  sdo_r,      sdo_s;
    logic [1:0]  mode_r,     mode_s;
    logic        busy_r,     busy_s;
    logic        done_r,     done_s;
    logic        ready_r,    ready_s;
    logic        accept_s;

    assign accept_s = in_req_valid_i & ready_r;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        half_cnt_s = half_cnt_r;
        per_cnt_s  = per_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        shreg_s    = shreg_r;
        quad_s     = quad_r;
        sck_s      = sck_r;
        cs_s       = cs_r;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s    = ST_SETUP;
                    half_cnt_s = HALF_RELOAD;
                    quad_s     = in_quad_en_i;
                    cs_s       = 1'b0;
                    sck_s      = 1'b0;
                    if (in_req_op_i) begin
                        // Register-0 write: command then low data byte, left-aligned.
                        shreg_s   = {8'h01, in_req_data_i[7:0], 56'h0};
                        per_cnt_s = in_quad_en_i ? 7'd4 : 7'd16;
                    end else begin
                        shreg_s   = {8'h02, in_req_addr_i, in_req_data_i};
                        per_cnt_s = in_quad_en_i ? 7'd18 : 7'd72;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (half_cnt_r == 8'd0) begin
                    state_s    = ST_SHIFT;
                    sck_s      = 1'b1;
                    half_cnt_s = HALF_RELOAD;
                end else begin
                    half_cnt_s = half_cnt_r - 8'd1;
                end
            end
            ST_SHIFT: begin
                if (half_cnt_r == 8'd0) begin
                    half_cnt_s = HALF_RELOAD;
                    if (sck_r) begin
                        // Falling edge: advance data so it is stable before the next rise.
                        sck_s   = 1'b0;
                        shreg_s = quad_r ? {shreg_r[67:0], 4'h0} : {shreg_r[70:0], 1'b0};
                    end else if (per_cnt_r == 7'd1) begin
                        state_s = ST_HOLD;
                    end else begin
                        sck_s     = 1'b1;
                        per_cnt_s = per_cnt_r - 7'd1;
                    end
                end else begin
                    half_cnt_s = half_cnt_r - 8'd1;
                end
            end
            ST_HOLD: begin
                if (half_cnt_r == 8'd0) begin
                    state_s   = ST_GAP;
                    cs_s      = 1'b1;
                    done_s    = 1'b1;
                    gap_cnt_s = GAP_RELOAD;
                end else begin
                    half_cnt_s = half_cnt_r - 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 16'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cs_s    = 1'b1;
                sck_s   = 1'b0;
            end
        endcase

        busy_s  = (state_s != ST_IDLE);
        ready_s = (state_s == ST_IDLE);
        if (!cs_s && quad_s) begin
            mode_s = 2'b01;
        end else begin
            mode_s = 2'b00;
        end
        if (cs_s) begin
            sdo_s = 4'h0;
        end else if (quad_s) begin
            sdo_s = shreg_s[71:68];
        end else begin
            sdo_s = {3'b000, shreg_s[71]};
        end
    end

    // State and output registers; reset raises CS at once and abandons any frame.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_r    <= ST_IDLE;
            half_cnt_r <= 8'd0;
            per_cnt_r  <= 7'd0;
            gap_cnt_r  <= 16'd0;
            shreg_r    <= 72'h0;
            quad_r     <= 1'b0;
            sck_r      <= 1'b0;
            cs_r       <= 1'b1;
            sdo_r      <= 4'h0;
            mode_r     <= 2'b00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            half_cnt_r <= half_cnt_s;
            per_cnt_r  <= per_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            shreg_r    <= shreg_s;
            quad_r     <= quad_s;
            sck_r      <= sck_s;
            cs_r       <= cs_s;
            sdo_r      <= sdo_s;
            mode_r     <= mode_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            ready_r    <= ready_s;
        end
    end

    assign out_req_ready_o = ready_r;
    assign out_spi_clk_o   = sck_r;
    assign out_spi_cs_o    = cs_r;
    assign out_spi_mode_o  = mode_r;
    assign out_spi_sdo0_o  = sdo_r[0];
    assign out_spi_sdo1_o  = sdo_r[1];
    assign out_spi_sdo2_o  = sdo_r[2];
    assign out_spi_sdo3_o  = sdo_r[3];
    assign out_busy_o      = busy_r;
    assign out_done_o      = done_r;

endmodule

// File: tb/tb_spi_boot_master.sv
// Self-checking bench for spi_boot_master: frames captured on SCK rising
// edges are compared against a frame model built from the command rules.
module tb_spi_boot_master;

    localparam int CD  = 2;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_req_valid_i = 1'b0;
    logic        in_req_op_i = 1'b0;
    logic [31:0] in_req_addr_i = 32'h0;
    logic [31:0] in_req_data_i = 32'h0;
    logic        in_quad_en_i = 1'b0;
    logic        out_req_ready_o, out_spi_clk_o, out_spi_cs_o;
    logic [1:0]  out_spi_mode_o;
    logic        out_spi_sdo0_o, out_spi_sdo1_o, out_spi_sdo2_o, out_spi_sdo3_o;
    logic        out_busy_o, out_done_o;

    spi_boot_master #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
        .in_clk(clk), .in_rst(rst),
        .in_req_valid_i(in_req_valid_i), .out_req_ready_o(out_req_ready_o),
        .in_req_op_i(in_req_op_i), .in_req_addr_i(in_req_addr_i),
        .in_req_data_i(in_req_data_i), .in_quad_en_i(in_quad_en_i),
        .out_spi_clk_o(out_spi_clk_o), .out_spi_cs_o(out_spi_cs_o),
        .out_spi_mode_o(out_spi_mode_o),
        .out_spi_sdo0_o(out_spi_sdo0_o), .out_spi_sdo1_o(out_spi_sdo1_o),
        .out_spi_sdo2_o(out_spi_sdo2_o), .out_spi_sdo3_o(out_spi_sdo3_o),
        .out_busy_o(out_busy_o), .out_done_o(out_done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected frames, oldest first.
    logic [71:0] exp_bits_q[$];
    int          exp_n_q[$];
    bit          exp_quad_q[$];

    // Frame model: right-aligned bit string and its length.
    task automatic model(input bit op, input logic [31:0] a, input logic [31:0] d,
                         output logic [71:0] bits, output int n);
        if (op) begin
            bits = {56'h0, 8'h01, d[7:0]};
            n    = 16;
        end else begin
            bits = {8'h02, a, d};
            n    = 72;
        end
    endtask

    function automatic int cs_low_len(input int n, input bit q);
        int nsck;
        nsck = q ? n / 4 : n;
        return 2 * CD + 2 * CD * nsck;
    endfunction

    // Monitor state
    bit          in_frame = 0;
    bit          seen_frame = 0;
    bit          prev_sck = 0;
    int          cs_len = 0;
    int          rises = 0;
    int          hi_run = 0;
    int          frames_done = 0;
    int          done_pulses = 0;
    int          idle_bad = 0;
    bit          mode_bad = 0;
    bit          lines_bad = 0;
    logic [71:0] cap = 72'h0;

    task automatic frame_end();
        logic [71:0] eb;
        int          en;
        bit          eq;
        if (exp_bits_q.size() == 0) begin
            check("unexpected_frame", 72'd1, 72'd0);
        end else begin
            eb = exp_bits_q.pop_front();
            en = exp_n_q.pop_front();
            eq = exp_quad_q.pop_front();
            check("frame_bits", cap, eb);
            check("sck_rises", 72'(rises), 72'(eq ? en / 4 : en));
            check("cs_low_cycles", 72'(cs_len), 72'(cs_low_len(en, eq)));
            check("mode_in_frame", 72'(mode_bad), 72'd0);
            check("unused_lines", 72'(lines_bad), 72'd0);
            frames_done++;
        end
    endtask

    // Monitor sampled on the falling in_clk edge, away from DUT updates.
    initial begin
        bit q;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame   = 0;
                seen_frame = 0;
                prev_sck   = 0;
                hi_run     = 0;
            end else begin
                if (out_done_o) done_pulses++;
                q = (exp_quad_q.size() > 0) ? exp_quad_q[0] : 1'b0;
                if (!out_spi_cs_o) begin
                    if (!in_frame) begin
                        in_frame  = 1;
                        cs_len    = 0;
                        rises     = 0;
                        cap       = 72'h0;
                        mode_bad  = 0;
                        lines_bad = 0;
                        if (seen_frame) check("cs_gap", 72'(hi_run >= GAP), 72'd1);
                    end
                    cs_len++;
                    if (out_spi_clk_o && !prev_sck) begin
                        rises++;
                        if (q) cap = {cap[67:0], out_spi_sdo3_o, out_spi_sdo2_o, out_spi_sdo1_o, out_spi_sdo0_o};
                        else   cap = {cap[70:0], out_spi_sdo0_o};
                    end
                    if (out_spi_mode_o != (q ? 2'b01 : 2'b00)) mode_bad = 1;
                    if (!q && (out_spi_sdo1_o || out_spi_sdo2_o || out_spi_sdo3_o)) lines_bad = 1;
                end else begin
                    if (in_frame) begin
                        in_frame   = 0;
                        frame_end();
                        seen_frame = 1;
                        hi_run     = 0;
                    end
                    hi_run++;
                    if (out_spi_mode_o != 2'b00 || out_spi_clk_o ||
                        {out_spi_sdo3_o, out_spi_sdo2_o, out_spi_sdo1_o, out_spi_sdo0_o} != 4'h0)
                        idle_bad++;
                end
                prev_sck = out_spi_clk_o;
            end
        end
    end

    task automatic present(input bit op, input logic [31:0] a, input logic [31:0] d, input bit q);
        logic [71:0] b;
        int          n;
        model(op, a, d, b, n);
        exp_bits_q.push_back(b);
        exp_n_q.push_back(n);
        exp_quad_q.push_back(q);
        in_req_op_i   = op;
        in_req_addr_i = a;
        in_req_data_i = d;
        in_quad_en_i  = q;
    endtask

    task automatic scramble();
        logic [31:0] r;
        r = $urandom();
        in_req_op_i   = r[0];
        in_quad_en_i  = r[1];
        in_req_addr_i = $urandom();
        in_req_data_i = $urandom();
    endtask

    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_req_ready_o && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = out_req_ready_o;
        if (!ok) check("ready_timeout", 72'd0, 72'd1);
    endtask

    // One request with full latency/gap checks; inputs scrambled mid-frame.
    task automatic send(input bit op, input logic [31:0] a, input logic [31:0] d, input bit q);
        bit ok;
        int k, g, n;
        logic [71:0] b;
        wait_ready(ok);
        if (ok) begin
            model(op, a, d, b, n);
            present(op, a, d, q);
            in_req_valid_i = 1'b1;
            @(posedge clk);
            #1;
            in_req_valid_i = 1'b0;
            scramble();
            check("ready_drop", 72'(out_req_ready_o), 72'd0);
            check("busy_set", 72'(out_busy_o), 72'd1);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!out_done_o && k < 3000);
            check("accept_to_done", 72'(k), 72'(1 + cs_low_len(n, q)));
            check("cs_high_at_done", 72'(out_spi_cs_o), 72'd1);
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!out_req_ready_o && g < 3000);
            check("gap_to_ready", 72'(g), 72'(GAP));
        end
    endtask

    initial begin
        bit          ok;
        int          bad, t, dp;
        logic [31:0] r;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_cs", 72'(out_spi_cs_o), 72'd1);
        check("rst_sck", 72'(out_spi_clk_o), 72'd0);
        check("rst_ready", 72'(out_req_ready_o), 72'd1);
        check("rst_mode", 72'(out_spi_mode_o), 72'd0);
        check("rst_sdo", 72'({out_spi_sdo3_o, out_spi_sdo2_o, out_spi_sdo1_o, out_spi_sdo0_o}), 72'd0);
        check("rst_busy_done", 72'({out_busy_o, out_done_o}), 72'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle: no SCK activity, CS high, ready held
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_spi_clk_o || !out_spi_cs_o || !out_req_ready_o || out_busy_o) bad++;
        end
        check("idle_quiet", 72'(bad), 72'd0);

        // Directed frames
        send(1'b0, 32'h1A10_7008, 32'hDEAD_BEEF, 1'b0);
        send(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0);
        send(1'b0, 32'h0000_0000, 32'h1234_5678, 1'b1);
        send(1'b1, 32'hFFFF_FFFF, 32'hABCD_EFA5, 1'b1);

        // Back-to-back: valid held high across three requests
        for (int i = 0; i < 3; i++) begin
            wait_ready(ok);
            if (ok) begin
                r = $urandom();
                present(r[0], $urandom(), $urandom(), r[1]);
                in_req_valid_i = 1'b1;
                @(posedge clk);
                #1;
                check("b2b_ready_drop", 72'(out_req_ready_o), 72'd0);
                scramble();
            end
        end
        in_req_valid_i = 1'b0;
        t = 0;
        while (exp_bits_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_frames_drained", 72'(exp_bits_q.size()), 72'd0);

        // Reset at the 10th SCK of a single WRITE_MEM
        wait_ready(ok);
        present(1'b0, 32'hCAFE_0123, 32'h8765_4321, 1'b0);
        in_req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_req_valid_i = 1'b0;
        @(negedge clk);
        t = 0;
        while (rises < 10 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("reached_sck10", 72'(rises >= 10), 72'd1);
        dp = done_pulses;
        #2 rst = 1'b1;
        #1;
        check("midrst_cs", 72'(out_spi_cs_o), 72'd1);
        check("midrst_sck", 72'(out_spi_clk_o), 72'd0);
        check("midrst_done", 72'(out_done_o), 72'd0);
        void'(exp_bits_q.pop_front());
        void'(exp_n_q.pop_front());
        void'(exp_quad_q.pop_front());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 72'(done_pulses), 72'(dp));
        check("midrst_ready", 72'(out_req_ready_o), 72'd1);
        send(1'b0, 32'h1A10_7008, 32'hDEAD_BEEF, 1'b0);

        // Randomized requests
        for (int i = 0; i < 10; i++) begin
            r = $urandom();
            send(r[0], $urandom(), $urandom(), r[1]);
        end

        repeat (10) @(negedge clk);
        check("frames_pending", 72'(exp_bits_q.size()), 72'd0);
        check("done_count", 72'(done_pulses), 72'(frames_done));
        check("idle_lines", 72'(idle_bad), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_boot_master.md
Name: spi_boot_master

Overview:
- Synthesizable SPI/QPI master that drives the SoC's SPI slave load port. It issues the same write transactions that boot code uses: memory writes, and register-0 writes (the QPI enable).
- Sits in the loader/boot subsystem. A sequencer or bridge presents one write request at a time; this block serialises it onto SCK/CS/SDO0-3 in SPI mode 0.
- Write-only: there is no read path, and SDI is not used.

Parameters:
- CLK_DIV, 2, in_clk cycles per SCK half-period; legal range 1..255.
- GAP_CYCLES, 4, minimum in_clk cycles CS stays high between transactions; must be >= 1.

Ports:
- in_clk  input  1  system clock
- in_rst  input  1  asynchronous reset, active-high
- in_req_valid_i  input  1  request valid
- out_req_ready_o  output  1  block idle, can accept a request
- in_req_op_i  input  1  0 = WRITE_MEM (cmd 0x02), 1 = WRITE_REG0 (cmd 0x01)
- in_req_addr_i  input  32  memory address (WRITE_MEM only)
- in_req_data_i  input  32  data word; WRITE_REG0 uses bits [7:0]
- in_quad_en_i  input  1  1 = send the whole transaction on 4 lines
- out_spi_clk_o  output  1  SCK
- out_spi_cs_o  output  1  chip select, active-low
- out_spi_mode_o  output  2  00 = standard, 01 = quad TX
- out_spi_sdo0_o .. out_spi_sdo3_o  output  1 each  serial data out
- out_busy_o  output  1  transaction in progress (CS low or in gap)
- out_done_o  output  1  one-cycle pulse in the cycle CS returns high

Behaviour:
- Reset values (applied asynchronously on in_rst):
  - SCK=0, CS=1, SDO0-3=0, mode=00, busy=0, done=0, ready=1.
  - FSM goes to IDLE.
  - A reset mid-transaction raises CS immediately. The partial frame is abandoned and no done pulse is generated.
- Handshake:
  - A request is accepted on a rising edge with valid & ready.
  - ready drops in the next cycle and stays low until the GAP state completes.
  - op, addr, data and quad_en are latched at acceptance. Later input changes are ignored.
- Frame contents:
  - WRITE_MEM = {0x02, addr[31:0], data[31:0]}, 72 bits.
  - WRITE_REG0 = {0x01, data[7:0]}, 16 bits.
  - Bits are sent MSB first.
- Line usage:
  - Single mode: 1 bit per SCK on SDO0. SDO1-3 are held 0. mode = 00.
  - Quad mode: 4 bits per SCK, with SDO3 = msb of the nibble and SDO0 = lsb. mode = 01 for the whole CS-low window, and returns to 00 when CS rises.
- SCK count per frame:
  - WRITE_MEM: 72 (single) / 18 (quad).
  - WRITE_REG0: 16 (single) / 4 (quad).
- FSM states and transitions:
  - IDLE: CS=1, SCK=0. On accept -> SETUP.
  - SETUP: CS=0; first bit(s) driven on SDO. Lasts CLK_DIV cycles -> SHIFT.
  - SHIFT: SCK toggles every CLK_DIV cycles, starting high (mode 0).
    - SDO changes only on SCK falling edges, so it is stable across each rising edge.
    - An SCK-period counter counts down. After the falling edge of the last period -> HOLD.
    - SCK is 0 on exit.
  - HOLD: CS=0, SCK=0 for CLK_DIV cycles -> GAP.
  - GAP: CS=1, done=1 in the first GAP cycle. Lasts GAP_CYCLES cycles -> IDLE, and ready returns to 1.
- Derived timings:
  - CS-low duration = CLK_DIV + 2*CLK_DIV*nSCK + CLK_DIV in_clk cycles.
  - Accept-to-done latency = 1 + CS-low duration cycles.
- Counters:
  - Half-period counter: 8 bits.
  - SCK-period counter: 7 bits.
  - Shift register: 72 bits; left shift of 1 (single) or 4 (quad) per falling edge.
- Boundary conditions:
  - valid asserted while busy: ignored, not queued.
  - valid & ready in the same cycle as done: impossible by construction, because ready stays 0 through GAP.
  - WRITE_REG0: data[31:8] is ignored.
  - CLK_DIV=1: SCK = in_clk/2, and the sequence is still glitch-free.
- busy is high from the cycle after acceptance through the last GAP cycle.

Test Plan:
- Reset then idle, CLK_DIV=2 -> CS=1, SCK=0, ready=1, mode=00, SDO=0; no SCK edges for 100 cycles.
- WRITE_MEM addr=0x1A10_7008, data=0xDEADBEEF, single -> CS low for exactly 292 cycles; 72 SCK rises; bits captured on rising edges equal 0x02_1A107008_DEADBEEF; done pulses once; ready returns 1 after 4 GAP cycles.
- WRITE_REG0 data=0x01, single (the QPI-enable sequence) -> CS low 68 cycles; 16 SCK; captured 0x0101; mode=00 throughout.
- WRITE_MEM addr=0x0000_0000, data=0x12345678, quad -> mode=01 during CS low; 18 SCK; nibbles on SDO3..0 = 0,2,0,0,0,0,0,0,0,0,1,2,3,4,5,6,7,8; CS low 76 cycles.
- Back-to-back: valid held high for 3 requests -> three frames, CS high >= 4 cycles between them; each request accepted only when ready=1; inputs changed mid-frame do not alter the transmitted bits.
- Assert in_rst at the 10th SCK of a single WRITE_MEM -> CS=1, SCK=0 in the same cycle (asynchronous); no done pulse; after release, ready=1 and the next request sends a full correct frame.
